// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB4 memory completer.
// Holds the FSM state encoding and the strobe-width helper.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        RESP    = 2'd2
    } apb_mem_state_t;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/apb_mem_timeout.sv
// Ack-wait watchdog for the memory request phase.
// Counts enabled cycles after a clear and flags the final one.
module apb_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] ONE  = CW'(1);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q <= '0;
                end else if (i_clr) begin
                    cnt_q <= '0;
                end else if (i_en && (cnt_q != TOP)) begin
                    cnt_q <= cnt_q + ONE;
                end
            end

            // Fires in the cycle whose missing ack completes the budget.
            assign o_expire = i_en && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer bridging transfers onto a req/ack memory port.
// Adds byte strobes, variable latency, ack timeout and range errors.
module apb4_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 7,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned ADDR_LIMIT     = 2**ADDR_WIDTH,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [ADDR_WIDTH-1:0]             i_PADDR,
    input  logic                              i_PWRITE,
    input  logic                              i_PSEL,
    input  logic                              i_PENABLE,
    input  logic [DATA_WIDTH-1:0]             i_PWDATA,
    input  logic [strb_width(DATA_WIDTH)-1:0] i_PSTRB,
    output logic                              o_PREADY,
    output logic [DATA_WIDTH-1:0]             o_PRDATA,
    output logic                              o_PSLVERR,
    output logic                              o_mem_req,
    output logic                              o_mem_we,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [DATA_WIDTH-1:0]             o_mem_wdata,
    output logic [strb_width(DATA_WIDTH)-1:0] o_mem_be,
    input  logic                              i_mem_ack,
    input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
    input  logic                              i_mem_err
);

    localparam int SW = strb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

    apb_mem_state_t state_q, state_d;

    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         be_q, be_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_exp;
    logic ack;
    logic setup;
    logic oob;

    assign ack   = i_mem_ack && req_q;
    assign setup = i_PSEL && !i_PENABLE;
    assign oob   = ({1'b0, i_PADDR} >= LIMIT);

    apb_mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (tmo_clr),
        .i_en     (tmo_en),
        .o_expire (tmo_exp)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    we_d    = i_PWRITE;
                    addr_d  = i_PADDR;
                    wdata_d = i_PWDATA;
                    be_d    = i_PWRITE ? i_PSTRB : '1;
                    if (oob) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        req_d   = 1'b1;
                        tmo_clr = 1'b1;
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                tmo_en = !ack;
                // Ack takes priority over a coincident timeout.
                if (ack) begin
                    req_d    = 1'b0;
                    err_d    = i_mem_err;
                    prdata_d = we_q ? '0 : i_mem_rdata;
                    state_d  = RESP;
                end else if (tmo_exp) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if ((state_d == RESP) && (state_q != RESP)) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
        end
    end

    assign o_PREADY    = pready_q;
    assign o_PSLVERR   = pslverr_q;
    assign o_PRDATA    = prdata_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench for apb4_mem_slave with a latency-programmable memory.
// Stimulus pushes expectations; monitors pop them on PREADY / mem_req.
module tb_apb4_mem_slave;
    import apb_mem_pkg::*;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int LIM = 100;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] i_PADDR = '0;
    logic          i_PWRITE = 1'b0;
    logic          i_PSEL = 1'b0;
    logic          i_PENABLE = 1'b0;
    logic [DW-1:0] i_PWDATA = '0;
    logic [SW-1:0] i_PSTRB = '0;
    logic          o_PREADY;
    logic [DW-1:0] o_PRDATA;
    logic          o_PSLVERR;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [SW-1:0] o_mem_be;
    logic          i_mem_ack = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          i_mem_err = 1'b0;

    always #5 clk = ~clk;

    apb4_mem_slave #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .ADDR_LIMIT     (LIM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_PADDR     (i_PADDR),
        .i_PWRITE    (i_PWRITE),
        .i_PSEL      (i_PSEL),
        .i_PENABLE   (i_PENABLE),
        .i_PWDATA    (i_PWDATA),
        .i_PSTRB     (i_PSTRB),
        .o_PREADY    (o_PREADY),
        .o_PRDATA    (o_PRDATA),
        .o_PSLVERR   (o_PSLVERR),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_err   (i_mem_err)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            issue;
    } resp_t;

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] be;
        int            len;
    } mreq_t;

    resp_t rq[$];
    mreq_t mq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int            m_dly = -1;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    int            late_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Memory model: acks after m_dly request cycles (-1 = never).
    initial begin : mem_model
        int mcnt;
        mcnt = 0;
        forever begin
            @(negedge clk);
            i_mem_ack   = 1'b0;
            i_mem_rdata = '0;
            i_mem_err   = 1'b0;
            if (o_mem_req) begin
                if (m_dly >= 0 && mcnt == m_dly) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = m_rdata;
                    i_mem_err   = m_err;
                end
                mcnt++;
            end else begin
                mcnt = 0;
                if (late_ack > 0) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = 32'hBAD0BAD0;
                    i_mem_err   = 1'b1;
                    late_ack--;
                end
            end
        end
    end

    initial begin : resp_mon
        resp_t r;
        logic  prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev) begin
                    chk("pready_one_cycle", 32'(o_PREADY), 32'd0);
                    chk("prdata_after", o_PRDATA, 32'd0);
                end
                if (o_PREADY) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_pready", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk({r.name, " prdata"}, o_PRDATA, r.rdata);
                        chk({r.name, " pslverr"}, 32'(o_PSLVERR),
                            32'(r.err));
                        chk({r.name, " latency"}, 32'(cyc - r.issue),
                            32'(r.lat));
                    end
                end
                prev = o_PREADY;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin : mreq_mon
        mreq_t m;
        logic  prev;
        int    len;
        prev = 1'b0;
        len  = 0;
        m.len = -1;
        forever begin
            @(negedge clk);
            if (o_mem_req && !prev) begin
                len = 1;
                if (mq.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                    m.len = -1;
                end else begin
                    m = mq.pop_front();
                    chk({m.name, " mem_we"}, 32'(o_mem_we), 32'(m.we));
                    chk({m.name, " mem_addr"}, 32'(o_mem_addr),
                        32'(m.addr));
                    chk({m.name, " mem_wdata"}, o_mem_wdata, m.wdata);
                    chk({m.name, " mem_be"}, 32'(o_mem_be), 32'(m.be));
                end
            end else if (o_mem_req) begin
                len++;
            end else if (prev && m.len >= 0) begin
                chk({m.name, " req_cycles"}, 32'(len), 32'(m.len));
            end
            prev = o_mem_req;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after RESP.
    task automatic xfer(input string nm, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input int dly,
                        input logic [DW-1:0] rd, input logic er,
                        input logic [DW-1:0] x_rd, input logic x_er,
                        input int x_lat, input int x_len,
                        input logic [SW-1:0] x_be);
        resp_t r;
        mreq_t m;
        logic  seen;
        m_dly   = dly;
        m_rdata = rd;
        m_err   = er;
        if (x_len != 0) begin
            m.name = nm; m.we = we; m.addr = a;
            m.wdata = wd; m.be = x_be; m.len = x_len;
            mq.push_back(m);
        end
        r.name = nm; r.rdata = x_rd; r.err = x_er;
        r.lat = x_lat; r.issue = cyc;
        rq.push_back(r);
        i_PSEL = 1'b1; i_PENABLE = 1'b0;
        i_PWRITE = we; i_PADDR = a; i_PWDATA = wd; i_PSTRB = st;
        @(posedge clk); #1;
        i_PENABLE = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = o_PREADY;
        end
        chk({nm, " pready_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        i_PSEL = 1'b0; i_PENABLE = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        #12;
        chk("rst_pready", 32'(o_PREADY), 32'd0);
        chk("rst_pslverr", 32'(o_PSLVERR), 32'd0);
        chk("rst_prdata", o_PRDATA, 32'd0);
        chk("rst_mem_ctl", 32'({o_mem_req, o_mem_we, o_mem_be}), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //   name        we a      wdata         st   dly rdata         er
        //   exp_rdata     er lat len be
        xfer("wr05", 1, 7'h05, 32'hDEADBEEF, 4'hF, 0, 32'hA5A5A5A5, 0,
             32'h0, 0, 2, 1, 4'hF);
        xfer("rd05", 0, 7'h05, 32'h0, 4'h0, 3, 32'hDEADBEEF, 0,
             32'hDEADBEEF, 0, 5, 4, 4'hF);
        xfer("wr_strb5", 1, 7'h0A, 32'h11223344, 4'h5, 1, 32'h0, 0,
             32'h0, 0, 3, 2, 4'h5);
        xfer("rd_oob100", 0, 7'd100, 32'h0, 4'h3, 0, 32'h77777777, 0,
             32'h0, 1, 1, 0, 4'h0);
        xfer("rd_99", 0, 7'd99, 32'h0, 4'h0, 0, 32'h0BADF00D, 0,
             32'h0BADF00D, 0, 2, 1, 4'hF);
        xfer("wr_oob127", 1, 7'h7F, 32'h12345678, 4'hF, 0, 32'h0, 0,
             32'h0, 1, 1, 0, 4'h0);
        xfer("rd_timeout", 0, 7'h20, 32'h0, 4'h0, -1, 32'h0, 0,
             32'h0, 1, 5, 4, 4'hF);

        late_ack = 3;
        repeat (5) @(posedge clk);
        #1;
        chk("late_ack_pready", 32'(o_PREADY), 32'd0);
        chk("late_ack_req", 32'(o_mem_req), 32'd0);
        chk("late_ack_state", 32'(dut.state_q), 32'(IDLE));

        xfer("wr_strb0", 1, 7'h03, 32'h00000055, 4'h0, 2, 32'h0, 0,
             32'h0, 0, 4, 3, 4'h0);
        xfer("rd_memerr", 0, 7'h06, 32'h0, 4'h0, 0, 32'h12345678, 1,
             32'h12345678, 1, 2, 1, 4'hF);

        // Abandon a read mid-MEM_REQ with an asynchronous reset.
        begin
            mreq_t m;
            m.name = "rd_reset"; m.we = 1'b0; m.addr = 7'h10;
            m.wdata = 32'h0; m.be = 4'hF; m.len = -1;
            mq.push_back(m);
        end
        m_dly = -1;
        i_PSEL = 1'b1; i_PENABLE = 1'b0; i_PWRITE = 1'b0;
        i_PADDR = 7'h10; i_PWDATA = 32'h0; i_PSTRB = 4'h0;
        @(posedge clk); #1;
        i_PENABLE = 1'b1;
        @(posedge clk); #2;
        chk("pre_reset_req", 32'(o_mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(o_mem_req), 32'd0);
        chk("async_rst_pready", 32'(o_PREADY), 32'd0);
        chk("async_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("async_rst_addr", 32'(o_mem_addr), 32'd0);
        i_PSEL = 1'b0; i_PENABLE = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("rd_after_rst", 0, 7'h05, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0,
             32'hCAFEF00D, 0, 2, 1, 4'hF);

        repeat (5) @(posedge clk);
        #1;
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("mreq_queue_empty", 32'(mq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
